// File: rtl/crop_ctrl_pkg.sv
// crop_ctrl_pkg: command opcodes and FSM state encoding for the crop window controller
package crop_ctrl_pkg;
   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_ZOOM_IN  = 3'd1;
   localparam logic [2:0] OP_ZOOM_OUT = 3'd2;
   localparam logic [2:0] OP_LEFT     = 3'd3;
   localparam logic [2:0] OP_RIGHT    = 3'd4;
   localparam logic [2:0] OP_UP       = 3'd5;
   localparam logic [2:0] OP_DOWN     = 3'd6;
   localparam logic [2:0] OP_RESET    = 3'd7;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_CLAMP = 2'd2;
endpackage

// File: rtl/crop_clamp.sv
// crop_clamp: saturates a signed window start coordinate to [0, limit]
module crop_clamp #(
   parameter int W = 11
) (
   input  logic signed [W+1:0] start_i,
   input  logic        [W-1:0] limit_i,
   output logic        [W-1:0] start_o
);
   // negative -> 0, beyond limit -> limit, otherwise pass through
   always_comb start_o = start_i[W+1] ? '0 : (start_i > $signed({2'b00, limit_i})) ? limit_i : start_i[W-1:0];
endmodule

// File: rtl/crop_window_ctrl.sv
// crop_window_ctrl: pan/zoom command FSM with frame-synchronous commit of the crop window
module crop_window_ctrl
   import crop_ctrl_pkg::*;
#(
   parameter int H_DISP = 1920,
   parameter int V_DISP = 1080,
   parameter int XW     = 11,
   parameter int YW     = 11,
   parameter int STEP_X = 64,
   parameter int STEP_Y = 36
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vs_i,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   output logic [XW-1:0] start_x,
   output logic [YW-1:0] start_y,
   output logic [XW-1:0] end_x,
   output logic [YW-1:0] end_y,
   output logic [1:0]    zoom_level,
   output logic          frame_update,
   output logic          busy
);
   localparam logic [XW-1:0] HD = XW'(H_DISP);
   localparam logic [YW-1:0] VD = YW'(V_DISP);
   localparam logic signed [XW+1:0] SX = (XW+2)'(STEP_X);
   localparam logic signed [YW+1:0] SY = (YW+2)'(STEP_Y);

   logic [1:0] state_q, state_d;
   logic [2:0] op_q;
   logic [1:0] wz_q, cz_q, cz_d, zoom_q;
   logic [XW-1:0] wx_q, sx_q, ex_q, w_old, lim_x, clx;
   logic [YW-1:0] wy_q, sy_q, ey_q, h_old, lim_y, cly;
   logic signed [XW+1:0] cx_q, cx_d, wxs;
   logic signed [YW+1:0] cy_q, cy_d, wys;
   logic dirty_q, vs_q, fu_q, zin, zout, commit, clamp_wr;

   // working-window size, unclamped next start/zoom and clamp limits
   always_comb begin
      w_old = HD >> wz_q;
      h_old = VD >> wz_q;
      wxs = $signed({2'b00, wx_q});
      wys = $signed({2'b00, wy_q});
      zin = (op_q == OP_ZOOM_IN) && (wz_q != 2'd3);
      zout = (op_q == OP_ZOOM_OUT) && (wz_q != 2'd0);
      cx_d = (op_q == OP_RESET) ? '0 :
             zin ? wxs + $signed({2'b00, w_old >> 2}) :
             zout ? wxs - $signed({2'b00, w_old >> 1}) :
             (op_q == OP_LEFT) ? wxs - SX :
             (op_q == OP_RIGHT) ? wxs + SX : wxs;
      cy_d = (op_q == OP_RESET) ? '0 :
             zin ? wys + $signed({2'b00, h_old >> 2}) :
             zout ? wys - $signed({2'b00, h_old >> 1}) :
             (op_q == OP_UP) ? wys - SY :
             (op_q == OP_DOWN) ? wys + SY : wys;
      cz_d = (op_q == OP_RESET) ? 2'd0 : zin ? wz_q + 2'd1 : zout ? wz_q - 2'd1 : wz_q;
      lim_x = HD - (HD >> cz_q);
      lim_y = VD - (VD >> cz_q);
      state_d = (state_q == ST_IDLE) ? (cmd_valid ? ST_CALC : ST_IDLE) :
                (state_q == ST_CALC) ? ST_CLAMP : ST_IDLE;
      commit = vs_i & ~vs_q;
      clamp_wr = state_q == ST_CLAMP;
   end

   crop_clamp #(.W(XW)) u_clamp_x (.start_i(cx_q), .limit_i(lim_x), .start_o(clx));
   crop_clamp #(.W(YW)) u_clamp_y (.start_i(cy_q), .limit_i(lim_y), .start_o(cly));

   // command FSM: latch op, compute in CALC, write clamped working window in CLAMP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q <= OP_NOP;
         cx_q <= '0;
         cy_q <= '0;
         cz_q <= '0;
         wx_q <= '0;
         wy_q <= '0;
         wz_q <= '0;
      end else begin
         state_q <= state_d;
         if (cmd_valid && cmd_ready) op_q <= cmd_op;
         if (state_q == ST_CALC) begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            cz_q <= cz_d;
         end
         if (clamp_wr) begin
            wx_q <= clx;
            wy_q <= cly;
            wz_q <= cz_q;
         end
      end
   end

   // frame commit: on vsync rise copy the pre-write working window; a same-cycle CLAMP keeps dirty set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q <= 1'b0;
         dirty_q <= 1'b0;
         fu_q <= 1'b0;
         zoom_q <= '0;
         sx_q <= '0;
         sy_q <= '0;
         ex_q <= HD;
         ey_q <= VD;
      end else begin
         vs_q <= vs_i;
         dirty_q <= clamp_wr | (dirty_q & ~commit);
         fu_q <= commit & dirty_q;
         if (commit && dirty_q) begin
            zoom_q <= wz_q;
            sx_q <= wx_q;
            sy_q <= wy_q;
            ex_q <= wx_q + w_old;
            ey_q <= wy_q + h_old;
         end
      end
   end

   assign cmd_ready = state_q == ST_IDLE;
   assign busy = dirty_q | (state_q != ST_IDLE);
   assign start_x = sx_q;
   assign start_y = sy_q;
   assign end_x = ex_q;
   assign end_y = ey_q;
   assign zoom_level = zoom_q;
   assign frame_update = fu_q;
endmodule

// File: doc/crop_window_ctrl.md
CROP_WINDOW_CTRL -- requirements
Module: crop_window_ctrl

Interface
REQ-001 SHALL have parameter H_DISP, default 1920, active frame width in pixels.
REQ-002 SHALL have parameter V_DISP, default 1080, active frame height in lines.
REQ-003 SHALL have parameter XW / YW, default 11 / 11, coordinate widths.
REQ-004 SHALL have parameter STEP_X / STEP_Y, default 64 / 36, pan step in pixels/lines.
REQ-005 SHALL have ports, one per line, in this order:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- vs_i  in  1  input vertical sync, active high; frame boundary reference.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  3  0 NOP, 1 ZOOM_IN, 2 ZOOM_OUT, 3 LEFT, 4 RIGHT, 5 UP, 6 DOWN, 7 RESET_VIEW.
- start_x  out  XW  committed window left edge, inclusive.
- start_y  out  YW  committed window top edge, inclusive.
- end_x  out  XW  committed right edge, exclusive.
- end_y  out  YW  committed bottom edge, exclusive.
- zoom_level  out  2  committed zoom, 0..3.
- frame_update  out  1  one-cycle pulse on commit.
- busy  out  1  high when uncommitted change pending or FSM not IDLE.

Function
REQ-006 Window size SHALL be w = H_DISP>>zoom, h = V_DISP>>zoom; end_x = start_x+w, end_y = start_y+h.
REQ-007 FSM states SHALL be IDLE, CALC, CLAMP; cmd_ready = 1 only in IDLE.
REQ-008 Accept in IDLE at cycle T -> CALC at T+1 -> CLAMP at T+2 -> IDLE at T+3 with working registers updated and dirty set.
REQ-009 CALC SHALL compute unclamped signed (XW+2 / YW+2 bit) start and new zoom from working registers.
REQ-010 ZOOM_IN, zoom<3: zoom+1, start_x += w_old/4, start_y += h_old/4 (centre preserved); zoom=3: no change.
REQ-011 ZOOM_OUT, zoom>0: zoom-1, start_x -= w_old/2, start_y -= h_old/2; zoom=0: no change.
REQ-012 LEFT/RIGHT SHALL subtract/add STEP_X to start_x; UP/DOWN SHALL subtract/add STEP_Y to start_y.
REQ-013 RESET_VIEW SHALL set zoom 0, start 0,0; NOP SHALL traverse the FSM and change nothing (dirty still set).
REQ-014 CLAMP SHALL saturate start_x to [0, H_DISP-w_new] and start_y to [0, V_DISP-h_new].
REQ-015 vs_i SHALL be registered once; commit event = rising edge of vs_i (vs_i=1, vs_q=0).
REQ-016 On commit with dirty=1, outputs SHALL load working registers in that cycle (pre-CLAMP-write values), frame_update pulses next cycle edge for exactly one cycle, dirty clears.
REQ-017 If CLAMP writes working registers in the same cycle as commit, dirty SHALL remain set and the new value commits at the following frame.
REQ-018 Commit with dirty=0 SHALL produce no frame_update and no output change.
REQ-019 Outputs SHALL never change other than on commit; multiple commands in one frame SHALL accumulate and commit together.
REQ-020 busy SHALL equal dirty OR (state != IDLE).

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, dirty 0, vs_q 0, zoom_level 0, start_x 0, start_y 0, end_x H_DISP, end_y V_DISP, frame_update 0, working registers equal to committed reset values.
REQ-022 Reset asserted mid-command (CALC/CLAMP) SHALL discard the command; first accept possible in cycle after rst_n release.

Structure
REQ-023 Package crop_ctrl_pkg SHALL hold the cmd_op opcode constants and the FSM state encoding.
REQ-024 Clamp/saturate arithmetic SHALL be a combinational sub-module crop_clamp (inputs: signed start, limit; output: clamped start), instantiated once per axis.

Verification
REQ-025 Reset, ZOOM_IN, then vs_i rising edge -> at commit start 480/270, end 1440/810, zoom 1, one frame_update pulse.
REQ-026 From REQ-025 state, RIGHT x10 within one frame, then vs edge -> start_x 960 (clamped), end_x 1920, single frame_update.
REQ-027 ZOOM_OUT at zoom 0 and ZOOM_IN x4 from zoom 0 -> zoom saturates at 0 and 3; at zoom 3 w=240, h=135.
REQ-028 Command whose CLAMP cycle coincides with vs edge -> prior working values commit; new value commits at next vs edge; busy high between.
REQ-029 cmd_valid held high continuously -> cmd_ready pattern 1,0,0 per command; rst_n pulse during CALC -> outputs at reset values, no commit on next vs edge.
